// File: rtl/cmd_spi_receiver_pkg.sv
// Shared definitions for the SPI command receiver.
// Holds the FSM state encoding, command word width and counter widths.
package cmd_spi_receiver_pkg;

  localparam int unsigned CMD_WIDTH  = 32;
  localparam int unsigned CNT_WIDTH  = 6;
  localparam int unsigned LCNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2,
    LATCH = 2'd3
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with rise/fall pulse detection on the synchronized level.
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   i_d            : asynchronous input
//   o_q            : synchronized level (cleared to 0 by reset)
//   o_rise_c       : one-cycle pulse on a synchronized 0->1 transition
//   o_fall_c       : one-cycle pulse on a synchronized 1->0 transition
module spi_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Synchronizer chain plus one flop of history for edge detection
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q      = r_sync[STAGES-1];
  assign o_rise_c = r_sync[STAGES-1] & ~r_prev;
  assign o_fall_c = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/cmd_spi_receiver.sv
// SPI mode-0 slave that receives 32-bit command words and hands them to the
// system controller with a latch_data pulse of LATCH_CYCLES cycles.
// Ports:
//   clock, reset_n        : system clock, synchronous active-low reset
//   spi_sck/cs_n/mosi     : asynchronous SPI inputs
//   spi_miso              : echo of the previous accepted command (CMD_ECHO_EN), else 0
//   cmd_data              : last accepted command word
//   latch_data            : command-valid pulse
//   frame_error           : one-cycle pulse on a rejected frame (short or overrun)
//   busy                  : high while the FSM is not IDLE
// Build option: define CMD_ECHO_EN to enable the MISO echo register.
module cmd_spi_receiver
  import cmd_spi_receiver_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned LATCH_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 spi_sck,
  input  logic                 spi_cs_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic [CMD_WIDTH-1:0] cmd_data,
  output logic                 latch_data,
  output logic                 frame_error,
  output logic                 busy
);

  logic w_sck_q, w_sck_rise, w_sck_fall;
  logic w_cs_q, w_cs_rise, w_cs_fall;
  logic w_mosi_q, w_mosi_rise, w_mosi_fall;
  logic w_unused_c;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clock(clock), .reset_n(reset_n), .i_d(spi_sck),
    .o_q(w_sck_q), .o_rise_c(w_sck_rise), .o_fall_c(w_sck_fall)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clock(clock), .reset_n(reset_n), .i_d(spi_cs_n),
    .o_q(w_cs_q), .o_rise_c(w_cs_rise), .o_fall_c(w_cs_fall)
  );
  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .clock(clock), .reset_n(reset_n), .i_d(spi_mosi),
    .o_q(w_mosi_q), .o_rise_c(w_mosi_rise), .o_fall_c(w_mosi_fall)
  );

  // Sync outputs not needed in every build
  assign w_unused_c = ^{w_sck_q, w_mosi_rise, w_mosi_fall, w_sck_fall, w_cs_q};

  state_t                r_state, w_next_state;
  logic [CMD_WIDTH-1:0]  r_shift, r_cmd;
  logic [CNT_WIDTH-1:0]  r_bit_cnt;
  logic [LCNT_WIDTH-1:0] r_lcnt;
  logic                  r_overrun, r_pend, r_latch, r_ferr, r_busy;
  logic                  w_clr_frame, w_shift_en, w_load_cmd, w_ferr;
  logic                  w_set_ovr, w_pend_nxt, w_latch_nxt;

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state and datapath control
  always_comb begin
    w_next_state = r_state;
    w_clr_frame  = 1'b0;
    w_shift_en   = 1'b0;
    w_load_cmd   = 1'b0;
    w_ferr       = 1'b0;
    w_set_ovr    = 1'b0;
    w_pend_nxt   = 1'b0;
    w_latch_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_next_state = SHIFT;
          w_clr_frame  = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_next_state = IDLE;
          w_ferr       = 1'b1;
        end else if (w_sck_rise) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == CNT_WIDTH'(CMD_WIDTH - 1)) w_next_state = FULL;
        end
      end
      FULL: begin
        if (w_cs_rise) begin
          if (r_overrun) begin
            w_next_state = IDLE;
            w_ferr       = 1'b1;
          end else begin
            w_next_state = LATCH;
            w_load_cmd   = 1'b1;
          end
        end else if (w_sck_rise) begin
          w_set_ovr = 1'b1;
        end
      end
      LATCH: begin
        // A new frame opening here is tracked and shifted so no SCK edge is lost
        w_pend_nxt  = r_pend;
        w_latch_nxt = (r_lcnt < LCNT_WIDTH'(LATCH_CYCLES));
        if (w_cs_fall) begin
          w_pend_nxt  = 1'b1;
          w_clr_frame = 1'b1;
        end else if (r_pend && w_cs_rise) begin
          w_pend_nxt = 1'b0;
          w_ferr     = 1'b1;
        end else if (r_pend && w_sck_rise) begin
          w_shift_en = 1'b1;
        end
        if (r_lcnt == LCNT_WIDTH'(LATCH_CYCLES)) begin
          w_next_state = w_pend_nxt ? SHIFT : IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Shift register, counters, flags and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_overrun <= 1'b0;
      r_cmd     <= '0;
      r_pend    <= 1'b0;
      r_lcnt    <= '0;
      r_latch   <= 1'b0;
      r_ferr    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_clr_frame) begin
        r_shift   <= '0;
        r_bit_cnt <= '0;
        r_overrun <= 1'b0;
      end else if (w_shift_en) begin
        r_shift   <= {r_shift[CMD_WIDTH-2:0], w_mosi_q};
        r_bit_cnt <= r_bit_cnt + CNT_WIDTH'(1);
      end
      if (w_set_ovr)  r_overrun <= 1'b1;
      if (w_load_cmd) r_cmd     <= r_shift;
      r_pend  <= w_pend_nxt;
      r_lcnt  <= (r_state == LATCH) ? r_lcnt + LCNT_WIDTH'(1) : '0;
      r_latch <= w_latch_nxt;
      r_ferr  <= w_ferr;
      r_busy  <= (w_next_state != IDLE);
    end
  end

  assign cmd_data    = r_cmd;
  assign latch_data  = r_latch;
  assign frame_error = r_ferr;
  assign busy        = r_busy;

`ifdef CMD_ECHO_EN
  logic [CMD_WIDTH-1:0] r_echo;

  // Echo of the previous command, loaded at frame start and shifted on SCK fall
  always_ff @(posedge clock) begin
    if (!reset_n)                    r_echo <= '0;
    else if (w_cs_fall)              r_echo <= r_cmd;
    else if (w_sck_fall && !w_cs_q)  r_echo <= {r_echo[CMD_WIDTH-2:0], 1'b0};
  end

  assign spi_miso = r_echo[CMD_WIDTH-1];
`else
  assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_spi_receiver.sv
module tb_cmd_spi_receiver;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        spi_sck, spi_cs_n, spi_mosi;
  logic        spi_miso;
  logic [31:0] cmd_data;
  logic        latch_data, frame_error, busy;

  cmd_spi_receiver #(.SYNC_STAGES(2), .LATCH_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .cmd_data(cmd_data), .latch_data(latch_data), .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  // Output monitor: running totals sampled on the falling edge
  int          cyc = 0, lat_cyc = 0, lat_pulses = 0, ferr_cyc = 0, ferr_pulses = 0;
  int          cyc_cmd_chg = 0, cyc_lat_rise = 0, miso_high = 0;
  logic        prev_lat = 1'b0, prev_ferr = 1'b0;
  logic [31:0] prev_cmd = 32'h0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (latch_data === 1'b1) lat_cyc = lat_cyc + 1;
    if (latch_data === 1'b1 && prev_lat !== 1'b1) begin
      lat_pulses   = lat_pulses + 1;
      cyc_lat_rise = cyc;
    end
    if (frame_error === 1'b1) ferr_cyc = ferr_cyc + 1;
    if (frame_error === 1'b1 && prev_ferr !== 1'b1) ferr_pulses = ferr_pulses + 1;
    if (cmd_data !== prev_cmd) cyc_cmd_chg = cyc;
    if (spi_miso === 1'b1) miso_high = miso_high + 1;
    prev_lat  = latch_data;
    prev_ferr = frame_error;
    prev_cmd  = cmd_data;
  end

  int n_total = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic cs_fall();
    spi_cs_n = 1'b0;
    clk_wait(2);
  endtask

  task automatic cs_rise();
    clk_wait(4);
    spi_cs_n = 1'b1;
    clk_wait(20);
  endtask

  // SCK = clock/8, MOSI changes while SCK low; MISO captured just before each rise
  task automatic shift_bits(input logic [31:0] d, input int n, output logic [31:0] cap);
    cap = 32'h0;
    for (int i = 0; i < n; i++) begin
      spi_mosi = (i < 32) ? d[31 - i] : 1'b0;
      clk_wait(4);
      cap = {cap[30:0], spi_miso};
      spi_sck = 1'b1;
      clk_wait(4);
      spi_sck = 1'b0;
    end
  endtask

  typedef struct {
    logic [31:0] data;
    int          nbits;
    logic [31:0] exp_cmd;
    int          exp_lat_cyc;
    int          exp_lat_pulses;
    int          exp_ferr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] cap;
    int a_lc, a_lp, a_fc, a_fp;

    vecs[0] = '{32'hC4000000, 32, 32'hC4000000, 2, 1, 0};
    vecs[1] = '{32'hDEADBEEF, 20, 32'hC4000000, 0, 0, 1};
    vecs[2] = '{32'h12345678, 33, 32'hC4000000, 0, 0, 1};
    vecs[3] = '{32'hA5A5A5A5, 32, 32'hA5A5A5A5, 2, 1, 0};
    vecs[4] = '{32'h00000000, 32, 32'h00000000, 2, 1, 0};
    vecs[5] = '{32'hFFFFFFFF,  0, 32'h00000000, 0, 0, 1};
    vecs[6] = '{32'hFFFFFFFF, 31, 32'h00000000, 0, 0, 1};
    vecs[7] = '{32'hFFFFFFFF, 32, 32'hFFFFFFFF, 2, 1, 0};

    reset_n = 1'b0; spi_cs_n = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    clk_wait(3);
    check("rst cmd_data", cmd_data, 32'h0);
    check("rst latch_data", {31'h0, latch_data}, 32'h0);
    check("rst frame_error", {31'h0, frame_error}, 32'h0);
    check("rst busy", {31'h0, busy}, 32'h0);
    check("rst spi_miso", {31'h0, spi_miso}, 32'h0);
    reset_n = 1'b1;
    clk_wait(5);
    check("post-rst busy", {31'h0, busy}, 32'h0);

    for (int i = 0; i < 8; i++) begin
      a_lc = lat_cyc; a_lp = lat_pulses; a_fc = ferr_cyc; a_fp = ferr_pulses;
      cs_fall();
      shift_bits(vecs[i].data, vecs[i].nbits, cap);
      cs_rise();
      check($sformatf("v%0d cmd_data", i), cmd_data, vecs[i].exp_cmd);
      check($sformatf("v%0d latch cycles", i), 32'(lat_cyc - a_lc), 32'(vecs[i].exp_lat_cyc));
      check($sformatf("v%0d latch pulses", i), 32'(lat_pulses - a_lp), 32'(vecs[i].exp_lat_pulses));
      check($sformatf("v%0d ferr cycles", i), 32'(ferr_cyc - a_fc), 32'(vecs[i].exp_ferr));
      check($sformatf("v%0d ferr pulses", i), 32'(ferr_pulses - a_fp), 32'(vecs[i].exp_ferr));
      check($sformatf("v%0d busy idle", i), {31'h0, busy}, 32'h0);
    end

    // SCK toggling with cs_n high must be ignored
    a_lp = lat_pulses; a_fp = ferr_pulses;
    shift_bits(32'h0, 5, cap);
    clk_wait(10);
    check("sck idle busy", {31'h0, busy}, 32'h0);
    check("sck idle cmd", cmd_data, 32'hFFFFFFFF);
    check("sck idle latch", 32'(lat_pulses - a_lp), 32'h0);
    check("sck idle ferr", 32'(ferr_pulses - a_fp), 32'h0);

    // latch_data rises one cycle after cmd_data loads
    cs_fall();
    shift_bits(32'h0F0F0F0F, 32, cap);
    cs_rise();
    check("lat cmd", cmd_data, 32'h0F0F0F0F);
    check("lat cmd->latch", 32'(cyc_lat_rise - cyc_cmd_chg), 32'd1);

    // Back-to-back frames, second cs_n fall lands in LATCH
    a_lc = lat_cyc; a_lp = lat_pulses; a_fp = ferr_pulses;
    cs_fall();
    shift_bits(32'h0001ABCD, 32, cap);
    clk_wait(4);
    spi_cs_n = 1'b1;
    clk_wait(1);
    spi_cs_n = 1'b0;
    shift_bits(32'h4402FFFF, 32, cap);
    cs_rise();
    check("b2b latch pulses", 32'(lat_pulses - a_lp), 32'd2);
    check("b2b latch cycles", 32'(lat_cyc - a_lc), 32'd4);
    check("b2b ferr", 32'(ferr_pulses - a_fp), 32'h0);
    check("b2b cmd", cmd_data, 32'h4402FFFF);

    // Reset at bit 16; remainder of that frame must be ignored
    a_lp = lat_pulses; a_fp = ferr_pulses;
    cs_fall();
    shift_bits(32'hAAAAAAAA, 16, cap);
    reset_n = 1'b0;
    clk_wait(2);
    check("midrst busy", {31'h0, busy}, 32'h0);
    reset_n = 1'b1;
    shift_bits(32'hAAAA0000, 16, cap);
    cs_rise();
    check("midrst latch", 32'(lat_pulses - a_lp), 32'h0);
    check("midrst ferr", 32'(ferr_pulses - a_fp), 32'h0);
    check("midrst cmd", cmd_data, 32'h0);
    check("midrst busy idle", {31'h0, busy}, 32'h0);
    a_lc = lat_cyc; a_fp = ferr_pulses;
    cs_fall();
    shift_bits(32'h80000000, 32, cap);
    cs_rise();
    check("after rst cmd", cmd_data, 32'h80000000);
    check("after rst latch cycles", 32'(lat_cyc - a_lc), 32'd2);
    check("after rst ferr", 32'(ferr_pulses - a_fp), 32'h0);

`ifdef CMD_ECHO_EN
    cs_fall();
    shift_bits(32'h12345678, 32, cap);
    cs_rise();
    cs_fall();
    shift_bits(32'h0, 32, cap);
    cs_rise();
    check("echo miso", cap, 32'h12345678);
`else
    check("miso constant", 32'(miso_high), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
